ws2812_pixel_streamer: RTL and testbench

Upstream feeder for the WS2812 bit serializer. Holds a frame of per-LED colours written by the host logic, applies a global brightness scale, and streams the frame one 24-bit GRB word at a time to the serializer over a valid/ready handshake. It marks the last pixel so the serializer can insert the latch/reset gap after the final word.

---
 rtl/ws2812_pixel_streamer.sv | 152 +++++++++++++++
 tb/tb_ws2812_pixel_streamer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_pixel_streamer.sv
// ws2812_pixel_streamer
//
// Upstream feeder for the WS2812 bit serializer. Holds one frame of
// per-LED colours written by host logic, applies a global brightness
// scale captured at frame start, and streams the frame one 24-bit GRB
// word at a time over a valid/ready handshake. The final word of the
// frame is flagged with px_last so the serializer can insert the latch gap.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous, active-low reset (clears state and pixel store)
//   wr_en        pixel write strobe
//   wr_addr      pixel index, 0 = first LED in the chain
//   wr_data      colour as {R, G, B}
//   brightness   global scale, captured when a frame is accepted
//   frame_start  request one frame; honoured only while idle
//   busy         high while a frame is in progress
//   frame_done   one-cycle pulse after the last pixel is accepted
//   px_valid     px_data holds a word for the serializer
//   px_ready     serializer accepts the word
//   px_data      scaled colour as {G, R, B}
//   px_last      qualifies px_data as the last pixel of the chain
module ws2812_pixel_streamer #(
  parameter int NUM_LEDS = 8,
  parameter int AW       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  input  logic [7:0]    brightness,
  input  logic          frame_start,
  output logic          busy,
  output logic          frame_done,
  output logic          px_valid,
  input  logic          px_ready,
  output logic [23:0]   px_data,
  output logic          px_last
);

  localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_LEDS - 1);
  localparam logic [AW:0]   LED_COUNT = (AW + 1)'(NUM_LEDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  // Scale one 8-bit component: (c * (b + 1)) >> 8. The product never
  // exceeds 255 * 256, so 16 bits hold it and bits [15:8] are the result.
  function automatic logic [7:0] scale_component(input logic [7:0] c,
                                                 input logic [7:0] b);
    return 8'(({8'd0, c} * ({8'd0, b} + 16'd1)) >> 8);
  endfunction

  // Scale an {R, G, B} pixel and reorder it into the {G, R, B} wire format.
  function automatic logic [23:0] scale_pixel(input logic [23:0] rgb,
                                              input logic [7:0]  b);
    return {scale_component(rgb[15:8], b),
            scale_component(rgb[23:16], b),
            scale_component(rgb[7:0], b)};
  endfunction

  logic [23:0]   mem_r [NUM_LEDS];
  state_t        state_r;
  logic [AW-1:0] idx_r;
  logic [7:0]    bright_q_r;
  logic          px_valid_r;
  logic          px_last_r;
  logic [23:0]   px_data_r;
  logic          frame_done_r;
  logic          busy_r;
  logic          wr_in_range_s;

  // Out-of-range indices exist whenever NUM_LEDS is not a power of two.
  assign wr_in_range_s = ({1'b0, wr_addr} < LED_COUNT);

  // Pixel store: host writes land at any time; reset clears every entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        mem_r[i] <= 24'd0;
      end
    end else if (wr_en && wr_in_range_s) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Frame sequencer: fetch one pixel, offer it, wait for the handshake.
  // A fetch reads the store before a same-cycle write updates it, so a
  // write only reaches the current frame if it lands before that fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      idx_r        <= '0;
      bright_q_r   <= 8'd0;
      px_valid_r   <= 1'b0;
      px_last_r    <= 1'b0;
      px_data_r    <= 24'd0;
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (frame_start) begin
            idx_r      <= '0;
            bright_q_r <= brightness;
            busy_r     <= 1'b1;
            state_r    <= LOAD;
          end
        end
        LOAD: begin
          px_data_r  <= scale_pixel(mem_r[idx_r], bright_q_r);
          px_valid_r <= 1'b1;
          px_last_r  <= (idx_r == LAST_IDX);
          state_r    <= SEND;
        end
        SEND: begin
          // px_valid is always high here, so px_ready alone completes it.
          if (px_ready) begin
            px_valid_r <= 1'b0;
            if (idx_r == LAST_IDX) begin
              px_last_r    <= 1'b0;
              frame_done_r <= 1'b1;
              busy_r       <= 1'b0;
              state_r      <= IDLE;
            end else begin
              idx_r   <= idx_r + AW'(1);
              state_r <= LOAD;
            end
          end
        end
        default: begin
          px_valid_r <= 1'b0;
          px_last_r  <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign px_valid   = px_valid_r;
  assign px_data    = px_data_r;
  assign px_last    = px_last_r;

endmodule

// File: tb/tb_ws2812_pixel_streamer.sv
// Self-checking bench for ws2812_pixel_streamer (NUM_LEDS=5, so that
// out-of-range write addresses are expressible). A transaction-level model
// predicts every output each cycle; directed frames are also checked
// against hand-computed words.
module tb_ws2812_pixel_streamer;

  localparam int N  = 5;
  localparam int AW = 3;

  typedef logic [23:0] frame_t [N];

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic [7:0]    brightness;
  logic          frame_start;
  logic          busy;
  logic          frame_done;
  logic          px_valid;
  logic          px_ready;
  logic [23:0]   px_data;
  logic          px_last;

  ws2812_pixel_streamer #(.NUM_LEDS(N), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .brightness(brightness), .frame_start(frame_start),
    .busy(busy), .frame_done(frame_done), .px_valid(px_valid),
    .px_ready(px_ready), .px_data(px_data), .px_last(px_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Colour scaling straight from the arithmetic rule, output in G,R,B order.
  function automatic logic [23:0] scale_px(input logic [23:0] rgb, input logic [7:0] b);
    int bb, r, g, bl;
    bb = int'(b) + 1;
    r  = int'(rgb[23:16]) * bb / 256;
    g  = int'(rgb[15:8])  * bb / 256;
    bl = int'(rgb[7:0])   * bb / 256;
    return {8'(g), 8'(r), 8'(bl)};
  endfunction

  // Reference model state: the frame is a list of pixels handed out one at a
  // time; each pixel is fetched one cycle after the frame starts or the
  // previous pixel is taken, then offered until accepted.
  logic [23:0] m_mem [N];
  logic        m_busy, m_valid, m_last, m_done, m_fetch_pending;
  logic [23:0] m_data;
  logic [7:0]  m_bq;
  int          m_nxt;
  bit          model_on = 1'b0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          done_cyc = 0;
  int          done_cnt = 0;
  logic [24:0] got_q [$];
  bit          hold_prev = 1'b0;
  logic [23:0] prev_data;
  logic        prev_last;

  // Monitor: compare outputs of the last edge, then predict the next edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (model_on) begin
        chk("busy", busy, m_busy);
        chk("frame_done", frame_done, m_done);
        chk("px_valid", px_valid, m_valid);
        chk("px_last", px_last, m_last);
        chk("px_data", px_data, m_data);
        if (hold_prev) begin
          chk("stall_valid", px_valid, 1'b1);
          chk("stall_data", px_data, prev_data);
          chk("stall_last", px_last, prev_last);
        end
      end
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (px_valid && px_ready && rst_n) got_q.push_back({px_last, px_data});
      hold_prev = px_valid && !px_ready && rst_n;
      prev_data = px_data;
      prev_last = px_last;

      if (!rst_n) begin
        for (int i = 0; i < N; i++) m_mem[i] = 24'd0;
        m_busy = 1'b0; m_valid = 1'b0; m_last = 1'b0; m_done = 1'b0;
        m_fetch_pending = 1'b0; m_data = 24'd0; m_bq = 8'd0; m_nxt = 0;
      end else begin
        m_done = 1'b0;
        if (!m_busy) begin
          if (frame_start) begin
            m_bq = brightness;
            m_busy = 1'b1;
            m_fetch_pending = 1'b1;
            m_nxt = 0;
            acc_cyc = cyc + 1;
          end
        end else if (m_fetch_pending) begin
          m_data = scale_px(m_mem[m_nxt], m_bq);
          m_valid = 1'b1;
          m_last = (m_nxt == N - 1);
          m_fetch_pending = 1'b0;
        end else if (m_valid && px_ready) begin
          m_valid = 1'b0;
          if (m_last) begin
            m_last = 1'b0;
            m_busy = 1'b0;
            m_done = 1'b1;
          end else begin
            m_nxt++;
            m_fetch_pending = 1'b1;
          end
        end
        if (wr_en && int'(wr_addr) < N) m_mem[wr_addr] = wr_data;
      end
      model_on = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int addr, input logic [23:0] data);
    wr_en = 1'b1; wr_addr = AW'(addr); wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input int start_cnt);
    for (int i = 0; i < 300 && done_cnt == start_cnt; i++) tick();
    chk("frame_completed", done_cnt - start_cnt, 1);
    tick();
  endtask

  task automatic run_frame(input logic [7:0] b, input logic [7:0] b_after);
    int s;
    s = done_cnt;
    got_q.delete();
    frame_start = 1'b1; brightness = b;
    tick();
    frame_start = 1'b0; brightness = b_after;
    wait_done(s);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20 && !px_valid; i++) tick();
    chk("wait_valid", px_valid, 1'b1);
  endtask

  // Start a frame with the serializer stalled and stop with pixel pix offered.
  task automatic goto_send(input int pix);
    got_q.delete();
    px_ready = 1'b0; frame_start = 1'b1; brightness = 8'd255;
    tick();
    frame_start = 1'b0;
    for (int p = 0; p <= pix; p++) begin
      wait_valid();
      if (p < pix) begin
        px_ready = 1'b1;
        tick();
        px_ready = 1'b0;
      end
    end
  endtask

  task automatic chk_frame(input string tag, input frame_t ew);
    logic [24:0] g;
    chk({tag, "_count"}, got_q.size(), N);
    for (int i = 0; i < N; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 25'h1FFFFFF;
      chk($sformatf("%s_word%0d", tag, i), g[23:0], ew[i]);
      chk($sformatf("%s_last%0d", tag, i), g[24], (i == N - 1));
    end
  endtask

  task automatic write_base();
    wr(0, 24'hFF0000); wr(1, 24'h00FF00); wr(2, 24'h0000FF);
    wr(3, 24'h123456); wr(4, 24'hABCDEF);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t ew;
    int s;
    logic [23:0] held;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = 24'd0;
    brightness = 8'd0; frame_start = 1'b0; px_ready = 1'b1;
    tick(); tick();
    chk("reset_busy", busy, 1'b0);
    chk("reset_valid", px_valid, 1'b0);
    chk("reset_data", px_data, 24'd0);
    chk("reset_done", frame_done, 1'b0);
    rst_n = 1'b1;
    tick();

    // Cleared store streams zeros; frame takes 2N+1 cycles.
    run_frame(8'd255, 8'd255);
    ew = '{24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
    chk_frame("zero", ew);
    chk("frame_cycles", done_cyc - acc_cyc + 1, 2 * N + 1);

    // Colour reorder at full brightness.
    write_base();
    run_frame(8'd255, 8'd255);
    ew = '{24'h00FF00, 24'hFF0000, 24'h0000FF, 24'h341256, 24'hCDABEF};
    chk_frame("grb", ew);

    // Half brightness; brightness changed after acceptance must not matter.
    wr(0, 24'h808080);
    run_frame(8'd127, 8'd255);
    chk("half_word0", got_q.size() > 0 ? got_q[0][23:0] : 24'hDEAD00, 24'h404040);
    chk("half_word1", got_q.size() > 1 ? got_q[1][23:0] : 24'hDEAD00, 24'h7F0000);
    wr(0, 24'hFFFFFF);
    run_frame(8'd0, 8'd0);
    chk("zero_bright_word0", got_q.size() > 0 ? got_q[0][23:0] : 24'hDEAD00, 24'h000000);

    // Stall for 10 cycles with a frame_start pulse that must be ignored.
    s = done_cnt;
    goto_send(0);
    held = px_data;
    for (int i = 0; i < 10; i++) begin
      frame_start = (i == 3);
      tick();
    end
    frame_start = 1'b0;
    chk("stall10_valid", px_valid, 1'b1);
    chk("stall10_data", px_data, held);
    px_ready = 1'b1;
    wait_done(s);
    for (int i = 0; i < 30; i++) tick();
    chk("single_done", done_cnt - s, 1);

    // Writes while pixel 1 is offered: later pixel changes, fetched ones keep.
    write_base();
    s = done_cnt;
    goto_send(1);
    wr(3, 24'h00FF00);
    wr(0, 24'hAAAAAA);
    wr(5, 24'h111111);
    wr(7, 24'h222222);
    px_ready = 1'b1;
    wait_done(s);
    ew = '{24'h00FF00, 24'hFF0000, 24'h0000FF, 24'hFF0000, 24'hCDABEF};
    chk_frame("midwrite", ew);

    // Reset while pixel 2 is offered.
    goto_send(2);
    rst_n = 1'b0;
    tick();
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_valid", px_valid, 1'b0);
    chk("midrst_last", px_last, 1'b0);
    chk("midrst_data", px_data, 24'd0);
    rst_n = 1'b1;
    px_ready = 1'b1;
    tick();
    run_frame(8'd255, 8'd255);
    ew = '{24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
    chk_frame("postrst", ew);

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      wr_en       = ($urandom_range(0, 3) == 0);
      wr_addr     = AW'($urandom_range(0, 7));
      wr_data     = 24'($urandom);
      brightness  = 8'($urandom);
      frame_start = ($urandom_range(0, 7) == 0);
      px_ready    = ($urandom_range(0, 2) != 0);
      rst_n       = ($urandom_range(0, 299) != 0);
      tick();
    end
    wr_en = 1'b0; frame_start = 1'b0; px_ready = 1'b1; rst_n = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    chk("final_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
